// File: rtl/inst_sequencer.sv
// inst_sequencer: program buffer plus fetch/issue sequencer for the MPU datapath.
// Words are loaded into a small buffer while IDLE. Execution then presents them
// one at a time on inst/inst_valid and waits for exec_done on each.
// Supports single-step pausing, an overflow halt, a watchdog halt and abort.
//
// Ports:
//   clk, rst         clock; synchronous active-low reset
//   load_valid/data  program word offered; load_ready = buffer accepts this cycle
//   clear            empty program buffer (IDLE only)
//   start            begin execution at entry 0
//   step_mode, step  pause after each instruction; step pulse resumes
//   abort            return to IDLE from any state
//   exec_done        datapath consumed current instruction; overflow valid with it
//   inst, inst_valid instruction to datapath, held until exec_done
//   pc, prog_len     current index and number of loaded words
//   busy, done       not IDLE; one-cycle pulse when the last instruction completes
//   err_ovf, err_to  sticky halt causes (overflow, exec_done timeout)
module inst_sequencer #(
   parameter int unsigned DEPTH   = 16,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load_valid,
   input  logic [15:0] load_data,
   output logic        load_ready,
   input  logic        clear,
   input  logic        start,
   input  logic        step_mode,
   input  logic        step,
   input  logic        abort,
   input  logic        exec_done,
   input  logic        overflow,
   output logic [15:0] inst,
   output logic        inst_valid,
   output logic [3:0]  pc,
   output logic [4:0]  prog_len,
   output logic        busy,
   output logic        done,
   output logic        err_ovf,
   output logic        err_to
);

   localparam int unsigned IW = 16;
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned WW = $clog2(TIMEOUT + 1);
   localparam logic [4:0]    DEPTH_L = 5'(DEPTH);
   localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_ISSUE = 3'd2,
      S_PAUSE = 3'd3,
      S_HALT  = 3'd4
   } state_t;

   state_t state, state_nxt;

   logic [IW-1:0] buf_mem [DEPTH];
   logic          buf_we;

   logic [WW-1:0] wdog, wdog_d;
   logic [3:0]    pc_d;
   logic [IW-1:0] inst_d;
   logic [4:0]    prog_len_d;
   logic          inst_valid_d, busy_d, done_d, err_ovf_d, err_to_d, load_ready_d;

   logic start_ok_c;
   logic is_last_c;
   logic wd_expire_c;

   // start is honoured only with a non-empty buffer and no simultaneous clear
   assign start_ok_c  = start && !clear && (prog_len != 5'd0);
   assign is_last_c   = (5'(pc) == (prog_len - 5'd1));
   assign wd_expire_c = (wdog == WD_LAST);

   // State register
   always_ff @(posedge clk) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // Next-state logic; abort overrides everything, including exec_done
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start_ok_c) state_nxt = S_FETCH;
         S_FETCH: state_nxt = S_ISSUE;
         S_ISSUE: begin
            if (exec_done) begin
               if (overflow)       state_nxt = S_HALT;
               else if (is_last_c) state_nxt = S_IDLE;
               else if (step_mode) state_nxt = S_PAUSE;
               else                state_nxt = S_FETCH;
            end else if (wd_expire_c) begin
               state_nxt = S_HALT;
            end
         end
         S_PAUSE: if (step || !step_mode) state_nxt = S_FETCH;
         S_HALT:  state_nxt = S_HALT;
         default: state_nxt = S_IDLE;
      endcase
      if (abort) state_nxt = S_IDLE;
   end

   // Output/datapath next values; status flags are derived from the next state
   always_comb begin
      pc_d       = pc;
      inst_d     = inst;
      prog_len_d = prog_len;
      wdog_d     = wdog;
      done_d     = 1'b0;
      err_ovf_d  = err_ovf;
      err_to_d   = err_to;
      buf_we     = 1'b0;
      case (state)
         S_IDLE: begin
            if (clear) begin
               prog_len_d = 5'd0;
            end else if (start_ok_c) begin
               pc_d = 4'd0;
            end else if (load_valid && load_ready) begin
               buf_we     = 1'b1;
               prog_len_d = prog_len + 5'd1;
            end
         end
         S_FETCH: begin
            if (!abort) begin
               inst_d = buf_mem[pc[AW-1:0]];
               wdog_d = '0;
            end
         end
         S_ISSUE: begin
            if (!abort) begin
               if (exec_done) begin
                  if (overflow)       err_ovf_d = 1'b1;
                  else if (is_last_c) done_d    = 1'b1;
                  else                pc_d      = pc + 4'd1;
               end else begin
                  // exec_done on the expiring cycle takes the branch above
                  wdog_d = wdog + WW'(1);
                  if (wd_expire_c) err_to_d = 1'b1;
               end
            end
         end
         default: begin
         end
      endcase
      if (abort && (state != S_IDLE)) begin
         err_ovf_d = 1'b0;
         err_to_d  = 1'b0;
      end
      inst_valid_d = (state_nxt == S_ISSUE);
      busy_d       = (state_nxt != S_IDLE);
      load_ready_d = (state_nxt == S_IDLE) && (prog_len_d < DEPTH_L);
   end

   // Registered outputs
   always_ff @(posedge clk) begin
      if (!rst) begin
         pc         <= 4'd0;
         inst       <= '0;
         prog_len   <= 5'd0;
         wdog       <= '0;
         inst_valid <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err_ovf    <= 1'b0;
         err_to     <= 1'b0;
         load_ready <= 1'b1;
      end else begin
         pc         <= pc_d;
         inst       <= inst_d;
         prog_len   <= prog_len_d;
         wdog       <= wdog_d;
         inst_valid <= inst_valid_d;
         busy       <= busy_d;
         done       <= done_d;
         err_ovf    <= err_ovf_d;
         err_to     <= err_to_d;
         load_ready <= load_ready_d;
      end
   end

   // Program buffer write port; contents are not reset
   always_ff @(posedge clk) begin
      if (rst && buf_we) buf_mem[prog_len[AW-1:0]] <= load_data;
   end

endmodule

// File: tb/tb_inst_sequencer.sv
// Self-checking bench for inst_sequencer: behavioural model plus directed scenarios.
module tb_inst_sequencer;

   localparam int DEPTH   = 16;
   localparam int TIMEOUT = 15;
   localparam int M_IDLE = 0, M_FETCH = 1, M_ISSUE = 2, M_PAUSE = 3, M_HALT = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        load_valid = 1'b0;
   logic [15:0] load_data = 16'h0;
   logic        load_ready;
   logic        clear = 1'b0;
   logic        start = 1'b0;
   logic        step_mode = 1'b0;
   logic        step = 1'b0;
   logic        abort = 1'b0;
   logic        exec_done = 1'b0;
   logic        overflow = 1'b0;
   logic [15:0] inst;
   logic        inst_valid;
   logic [3:0]  pc;
   logic [4:0]  prog_len;
   logic        busy;
   logic        done;
   logic        err_ovf;
   logic        err_to;

   inst_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
      .clear(clear), .start(start), .step_mode(step_mode), .step(step),
      .abort(abort), .exec_done(exec_done), .overflow(overflow),
      .inst(inst), .inst_valid(inst_valid), .pc(pc), .prog_len(prog_len),
      .busy(busy), .done(done), .err_ovf(err_ovf), .err_to(err_to)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model: mode, program queue, pc, current word, issue-cycle count
   int          m_st = M_IDLE;
   logic [15:0] m_prog[$];
   int          m_pc = 0;
   int          m_wd = 0;
   logic [15:0] m_inst = 16'h0;
   bit          m_done = 0, m_eovf = 0, m_eto = 0, m_live = 0;

   always @(posedge clk) begin
      m_done = 0;
      if (!rst) begin
         m_st = M_IDLE; m_prog.delete(); m_pc = 0; m_wd = 0;
         m_inst = 16'h0; m_eovf = 0; m_eto = 0; m_live = 1;
      end else if (abort && m_st != M_IDLE) begin
         m_st = M_IDLE; m_eovf = 0; m_eto = 0;
      end else begin
         case (m_st)
            M_IDLE: begin
               if (clear) m_prog.delete();
               else if (start && m_prog.size() > 0) begin m_st = M_FETCH; m_pc = 0; end
               else if (load_valid && m_prog.size() < DEPTH) m_prog.push_back(load_data);
            end
            M_FETCH: begin m_inst = m_prog[m_pc]; m_wd = 0; m_st = M_ISSUE; end
            M_ISSUE: begin
               if (exec_done) begin
                  if (overflow) begin m_st = M_HALT; m_eovf = 1; end
                  else if (m_pc == m_prog.size() - 1) begin m_st = M_IDLE; m_done = 1; end
                  else begin m_pc++; m_st = step_mode ? M_PAUSE : M_FETCH; end
               end else begin
                  m_wd++;
                  if (m_wd >= TIMEOUT) begin m_st = M_HALT; m_eto = 1; end
               end
            end
            M_PAUSE: if (step || !step_mode) m_st = M_FETCH;
            default: ;
         endcase
      end
   end

   // Per-cycle compare against the model, plus a log of issued words and done pulses
   logic [15:0] iss_inst[$];
   int          iss_pc[$];
   int          done_cnt = 0;
   logic        prev_iv = 1'b0;

   always @(negedge clk) begin
      if (m_live) begin
         chk("load_ready", 32'(load_ready), 32'(m_st == M_IDLE && m_prog.size() < DEPTH));
         chk("prog_len",   32'(prog_len),   32'(m_prog.size()));
         chk("inst_valid", 32'(inst_valid), 32'(m_st == M_ISSUE));
         chk("inst",       32'(inst),       32'(m_inst));
         chk("pc",         32'(pc),         32'(m_pc));
         chk("busy",       32'(busy),       32'(m_st != M_IDLE));
         chk("done",       32'(done),       32'(m_done));
         chk("err_ovf",    32'(err_ovf),    32'(m_eovf));
         chk("err_to",     32'(err_to),     32'(m_eto));
         if (inst_valid === 1'b1 && prev_iv !== 1'b1) begin
            iss_inst.push_back(inst);
            iss_pc.push_back(int'(pc));
         end
         if (done === 1'b1) done_cnt++;
         prev_iv = inst_valid;
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst = 1'b0; tick(); tick(); rst = 1'b1;
   endtask

   task automatic load_word(input logic [15:0] w);
      load_valid = 1'b1; load_data = w; tick(); load_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1; tick(); start = 1'b0;
   endtask

   task automatic wait_iv();
      bit ok = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (inst_valid === 1'b1) begin ok = 1; break; end
      end
      chk("wait_inst_valid", 32'(ok), 32'd1);
   endtask

   // Answer the current instruction after dly extra ISSUE cycles
   task automatic exec(input bit ovf, input int dly);
      wait_iv();
      repeat (dly) @(negedge clk);
      exec_done = 1'b1; overflow = ovf;
      tick();
      exec_done = 1'b0; overflow = 1'b0;
   endtask

   initial begin
      #300000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int d0, i0, cnt;
      logic [15:0] words[3];
      words[0] = 16'h1A23; words[1] = 16'h2B45; words[2] = 16'h3C67;

      // Reset values
      do_reset();
      chk("rst_load_ready", 32'(load_ready), 32'd1);
      chk("rst_prog_len",   32'(prog_len),   32'd0);
      chk("rst_inst",       32'(inst),       32'd0);

      // Three-word program, exec_done in the first ISSUE cycle
      d0 = done_cnt; i0 = iss_inst.size();
      for (int k = 0; k < 3; k++) load_word(words[k]);
      pulse_start();
      chk("start_lat_fetch", 32'(inst_valid), 32'd0);
      tick();
      chk("start_lat_issue", 32'(inst_valid), 32'd1);
      for (int k = 0; k < 3; k++) exec(1'b0, 0);
      tick(); tick();
      chk("seq_count", 32'(iss_inst.size() - i0), 32'd3);
      if (iss_inst.size() - i0 == 3) begin
         chk("seq_inst0", 32'(iss_inst[i0]),   32'h1A23);
         chk("seq_inst1", 32'(iss_inst[i0+1]), 32'h2B45);
         chk("seq_inst2", 32'(iss_inst[i0+2]), 32'h3C67);
         chk("seq_pc0", 32'(iss_pc[i0]),   32'd0);
         chk("seq_pc1", 32'(iss_pc[i0+1]), 32'd1);
         chk("seq_pc2", 32'(iss_pc[i0+2]), 32'd2);
      end
      chk("seq_done_once", 32'(done_cnt - d0), 32'd1);
      chk("seq_busy_after", 32'(busy), 32'd0);
      chk("seq_pc_held", 32'(pc), 32'd2);

      // Fill beyond capacity, then clear; empty start and stray step ignored
      do_reset();
      for (int k = 0; k < 17; k++) load_word(16'(16'h4000 + k));
      chk("full_prog_len", 32'(prog_len), 32'd16);
      chk("full_ready", 32'(load_ready), 32'd0);
      clear = 1'b1; load_valid = 1'b1; load_data = 16'hDEAD; tick();
      clear = 1'b0; load_valid = 1'b0;
      chk("clear_prog_len", 32'(prog_len), 32'd0);
      chk("clear_ready", 32'(load_ready), 32'd1);
      step = 1'b1; exec_done = 1'b1; tick(); step = 1'b0; exec_done = 1'b0;
      pulse_start(); tick();
      chk("empty_start_busy", 32'(busy), 32'd0);

      // Single step through a two-word program
      d0 = done_cnt; i0 = iss_inst.size();
      load_word(16'hA001); load_word(16'hA002);
      step_mode = 1'b1;
      pulse_start();
      exec(1'b0, 0);
      repeat (5) tick();
      chk("pause_iv", 32'(inst_valid), 32'd0);
      chk("pause_busy", 32'(busy), 32'd1);
      chk("pause_pc", 32'(pc), 32'd1);
      step = 1'b1; tick(); step = 1'b0;
      exec(1'b0, 2);
      tick();
      chk("step_done_once", 32'(done_cnt - d0), 32'd1);
      chk("step_issued", 32'(iss_inst.size() - i0), 32'd2);
      // Leaving PAUSE by dropping step_mode
      pulse_start();
      exec(1'b0, 0);
      repeat (3) tick();
      step_mode = 1'b0;
      exec(1'b0, 0);
      tick();
      chk("mode_clear_done", 32'(done_cnt - d0), 32'd2);

      // Overflow halt on word 1 of 4, then abort
      do_reset();
      for (int k = 0; k < 4; k++) load_word(16'(16'h5100 + k));
      pulse_start();
      exec(1'b0, 0);
      exec(1'b1, 1);
      step = 1'b1; exec_done = 1'b1; tick(); step = 1'b0; exec_done = 1'b0;
      repeat (2) tick();
      chk("ovf_flag", 32'(err_ovf), 32'd1);
      chk("ovf_pc", 32'(pc), 32'd1);
      chk("ovf_busy", 32'(busy), 32'd1);
      abort = 1'b1; tick(); abort = 1'b0;
      chk("ovf_abort_busy", 32'(busy), 32'd0);
      chk("ovf_abort_flag", 32'(err_ovf), 32'd0);
      chk("ovf_abort_len", 32'(prog_len), 32'd4);

      // Watchdog: withheld exec_done faults after 15 ISSUE cycles
      pulse_start();
      wait_iv();
      cnt = 1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (inst_valid === 1'b1) cnt++;
         else break;
      end
      chk("to_issue_cycles", 32'(cnt), 32'd15);
      chk("to_flag", 32'(err_to), 32'd1);
      abort = 1'b1; tick(); abort = 1'b0;
      chk("to_abort_flag", 32'(err_to), 32'd0);
      // exec_done on the 15th ISSUE cycle wins over the timeout
      pulse_start();
      wait_iv();
      repeat (14) @(negedge clk);
      exec_done = 1'b1; tick(); exec_done = 1'b0;
      chk("to_edge_flag", 32'(err_to), 32'd0);
      chk("to_edge_pc", 32'(pc), 32'd1);
      abort = 1'b1; tick(); abort = 1'b0;

      // abort together with exec_done mid-program
      do_reset();
      d0 = done_cnt;
      for (int k = 0; k < 3; k++) load_word(words[k]);
      pulse_start();
      exec(1'b0, 0);
      wait_iv();
      exec_done = 1'b1; abort = 1'b1; tick(); exec_done = 1'b0; abort = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_pc", 32'(pc), 32'd1);
      chk("abort_len", 32'(prog_len), 32'd3);
      tick();
      chk("abort_no_done", 32'(done_cnt - d0), 32'd0);

      // Reset in the middle of ISSUE
      pulse_start();
      wait_iv();
      rst = 1'b0; tick(); rst = 1'b1;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_iv", 32'(inst_valid), 32'd0);
      chk("midrst_inst", 32'(inst), 32'd0);
      chk("midrst_len", 32'(prog_len), 32'd0);
      tick();
      chk("midrst_ready", 32'(load_ready), 32'd1);
      chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);

      repeat (3) tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
